// File: rtl/alu_op_issue.sv
// ID->EX issue register: decodes RV32I ALU-class instructions into an ALU operation code and operands,
// and holds them behind a valid/ready handshake with stall and flush handling.
module alu_op_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     is_branch,
    output logic                     branch_inv,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 4'b1100;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]    dec_a;
    logic [DATA_WIDTH-1:0]    dec_b;
    logic                     dec_br;
    logic                     dec_inv;
    logic                     dec_ill;

    always_comb begin
        dec_op  = OP_ADD;
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_br  = 1'b0;
        dec_inv = 1'b0;
        dec_ill = 1'b0;
        unique case (opcode)
            OPC_R: begin
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     dec_op = OP_ADD;
                        else if (funct7 == F7_ALT) dec_op = OP_SUB;
                        else                       dec_ill = 1'b1;
                    end
                    3'b001: begin dec_op = OP_SLL; dec_ill = (funct7 != F7_ZERO); end
                    3'b010: begin dec_op = OP_SLT; dec_ill = (funct7 != F7_ZERO); end
                    3'b100: begin dec_op = OP_XOR; dec_ill = (funct7 != F7_ZERO); end
                    3'b110: begin dec_op = OP_OR;  dec_ill = (funct7 != F7_ZERO); end
                    3'b111: begin dec_op = OP_AND; dec_ill = (funct7 != F7_ZERO); end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec_op = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op = OP_SRA;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_I: begin
                dec_b = imm;
                unique case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        // Shift amount comes from the instruction, not the sign-extended immediate.
                        dec_b   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
                        dec_op  = OP_SLL;
                        dec_ill = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        dec_b = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
                        if (funct7 == F7_ZERO)     dec_op = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op = OP_SRA;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec_op = OP_ADD;
                dec_b  = imm;
            end
            OPC_LUI: begin
                dec_op = OP_ADD;
                dec_a  = '0;
                dec_b  = imm;
            end
            OPC_BRANCH: begin
                dec_br = 1'b1;
                unique case (funct3)
                    3'b000: begin dec_op = OP_EQ;  dec_inv = 1'b0; end
                    3'b001: begin dec_op = OP_EQ;  dec_inv = 1'b1; end
                    3'b100: begin dec_op = OP_SLT; dec_inv = 1'b0; end
                    3'b101: begin dec_op = OP_SLT; dec_inv = 1'b1; end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Unsupported instructions still issue, but as a harmless 0 + 0.
        if (dec_ill) begin
            dec_op  = OP_ADD;
            dec_a   = '0;
            dec_b   = '0;
            dec_br  = 1'b0;
            dec_inv = 1'b0;
        end
    end

    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
    logic [OPCODE_LENGTH-1:0] operation_q, operation_d;
    logic                     is_branch_q, is_branch_d;
    logic                     branch_inv_q, branch_inv_d;
    logic                     illegal_q, illegal_d;
    logic                     load;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        operation_d  = operation_q;
        is_branch_d  = is_branch_q;
        branch_inv_d = branch_inv_q;
        illegal_d    = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d  = 1'b1;
            src_a_d      = dec_a;
            src_b_d      = dec_b;
            operation_d  = dec_op;
            is_branch_d  = dec_br;
            branch_inv_d = dec_inv;
            illegal_d    = dec_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            operation_q  <= OP_ADD;
            is_branch_q  <= 1'b0;
            branch_inv_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            operation_q  <= operation_d;
            is_branch_q  <= is_branch_d;
            branch_inv_q <= branch_inv_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign SrcA       = src_a_q;
    assign SrcB       = src_b_q;
    assign Operation  = operation_q;
    assign is_branch  = is_branch_q;
    assign branch_inv = branch_inv_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode, handshake, stall, flush and reset behaviour.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        is_branch;
    logic        branch_inv;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Operation  (Operation),
        .is_branch  (is_branch),
        .branch_inv (branch_inv),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are read well clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        instr    = i;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic br, input logic inv, input logic ill);
        check({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, v});
        check({tag, ".Operation"},  {28'd0, Operation},  {28'd0, op});
        check({tag, ".SrcA"},       SrcA,                a);
        check({tag, ".SrcB"},       SrcB,                b);
        check({tag, ".is_branch"},  {31'd0, is_branch},  {31'd0, br});
        check({tag, ".branch_inv"}, {31'd0, branch_inv}, {31'd0, inv});
        check({tag, ".illegal"},    {31'd0, illegal},    {31'd0, ill});
        $display("txn %-10s valid=%0b op=%b a=%h b=%h br=%0b inv=%0b ill=%0b",
                 tag, out_valid, Operation, SrcA, SrcB, is_branch, branch_inv, illegal);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(32'h002081B3, 32'd1, 32'd2, 32'd0);
        step();
        step();
        expect_out("reset", 1'b0, 4'b0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // SUB x3,x1,x2
        reset_n = 1'b1;
        drive(32'h402081B3, 32'd10, 32'd3, 32'd0);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);
        step();
        expect_out("sub", 1'b1, 4'b0110, 32'd10, 32'd3, 1'b0, 1'b0, 1'b0);

        // SRAI x1,x1,4 with junk in the immediate's upper bits
        drive(32'h4040D093, 32'h80000000, 32'd0, 32'hFFFFF404);
        step();
        expect_out("srai", 1'b1, 4'b0111, 32'h80000000, 32'd4, 1'b0, 1'b0, 1'b0);

        drive(32'h00209063, 32'd5, 32'd5, 32'd0);   // BNE
        step();
        expect_out("bne", 1'b1, 4'b1000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);

        drive(32'h0020D063, 32'd4, 32'd9, 32'd0);   // BGE
        step();
        expect_out("bge", 1'b1, 4'b1100, 32'd4, 32'd9, 1'b1, 1'b1, 1'b0);

        drive(32'h0020C063, 32'd6, 32'd2, 32'd0);   // BLT
        step();
        expect_out("blt", 1'b1, 4'b1100, 32'd6, 32'd2, 1'b1, 1'b0, 1'b0);

        drive(32'h123450B7, 32'd99, 32'd77, 32'h12345000);   // LUI
        step();
        expect_out("lui", 1'b1, 4'b0010, 32'd0, 32'h12345000, 1'b0, 1'b0, 1'b0);

        // Stall: ADD held while XOR waits
        drive(32'h002081B3, 32'd7, 32'd8, 32'd0);
        step();
        expect_out("add", 1'b1, 4'b0010, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        drive(32'h0020C1B3, 32'hF0, 32'h0F, 32'd0);   // XOR
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", {31'd0, in_ready}, 32'd0);
            step();
            expect_out("stall", 1'b1, 4'b0010, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        expect_out("xor", 1'b1, 4'b0011, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b0);
        drive(32'h0020E1B3, 32'd1, 32'd2, 32'd0);   // OR
        step();
        expect_out("or", 1'b1, 4'b0001, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        drive(32'h0020F1B3, 32'd3, 32'd4, 32'd0);   // AND
        step();
        expect_out("and", 1'b1, 4'b0000, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);

        // Flush with a same-cycle SLL offered: it must never appear
        flush = 1'b1;
        drive(32'h002091B3, 32'd11, 32'd12, 32'd0);
        step();
        expect_out("flush", 1'b0, 4'b0000, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        expect_out("postflush", 1'b0, 4'b0000, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);

        // ADDI x1,x0,5 then consume with no new load: data holds
        in_valid = 1'b1;
        drive(32'h00500093, 32'd0, 32'd0, 32'd5);
        step();
        expect_out("addi5", 1'b1, 4'b0010, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        expect_out("consume", 1'b0, 4'b0010, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0);

        // Illegal: SLTU, then opcode 0x7F, then a legal ADDI clears the flag
        in_valid = 1'b1;
        drive(32'h0020B1B3, 32'd9, 32'd9, 32'd0);
        step();
        expect_out("sltu", 1'b1, 4'b0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(32'h0000007F, 32'd9, 32'd9, 32'd9);
        step();
        expect_out("opc7f", 1'b1, 4'b0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(32'hFFF08093, 32'd20, 32'd0, 32'hFFFFFFFF);   // ADDI x1,x1,-1
        step();
        expect_out("addim1", 1'b1, 4'b0010, 32'd20, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a transfer drops the entry
        drive(32'h0020C063, 32'd1, 32'd1, 32'd0);
        reset_n = 1'b0;
        step();
        expect_out("midreset", 1'b0, 4'b0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        check("idle.out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- ID→EX issue register that produces the ALU's operands and 4-bit Operation code.
- Decodes RV32I opcode/funct3/funct7 into the ALU Operation encoding, selects SrcA/SrcB, and registers the result behind a valid/ready handshake.
- Handles stall (back-pressure from EX) and flush (branch mispredict/trap).
- Drives alu.SrcA/SrcB/Operation directly; branch sense and illegal-op flags go to EX control.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, ALU Operation width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- flush  in  1  kill the held entry and any same-cycle input.
- in_valid  in  1  decode stage has an instruction.
- in_ready  out  1  register can accept this cycle.
- instr  in  32  raw instruction word.
- rs1_data  in  DATA_WIDTH  register-file read 1.
- rs2_data  in  DATA_WIDTH  register-file read 2.
- imm  in  DATA_WIDTH  sign-extended immediate from the immediate generator.
- out_valid  out  1  EX-side entry valid.
- out_ready  in  1  EX stage consumes this cycle.
- SrcA  out  DATA_WIDTH  ALU operand A.
- SrcB  out  DATA_WIDTH  ALU operand B.
- Operation  out  OPCODE_LENGTH  ALU op code.
- is_branch  out  1  entry is a conditional branch.
- branch_inv  out  1  taken = (ALUResult == 0) when set, else (ALUResult != 0).
- illegal  out  1  instruction not supported by the ALU.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-low: reset_n low at a rising clk edge resets the block.
- Reset values: out_valid=0, SrcA=0, SrcB=0, Operation=4'b0010, is_branch=0, branch_inv=0, illegal=0.
- Reset mid-transfer drops the entry with no output.
- Handshake: in_ready = !out_valid || out_ready (combinational).
- Load condition: in_valid && in_ready. On load, all outputs update on the next edge; latency is 1 cycle.
- Consume without load: out_valid→0 and data holds its last value.
- Stall (out_valid && !out_ready): every output holds stable, in_ready=0.
- Flush: priority over load and hold. Next edge out_valid=0 and the incoming instruction is dropped.
- Priority order: reset > flush > load > consume/hold.
- Operation codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, SLT 1100.
- R-type (0110011), SrcA=rs1, SrcB=rs2:
  - funct3 000: ADD if funct7=0000000, SUB if 0100000.
  - 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND (each requires funct7=0).
  - 101: SRL if funct7=0000000, SRA if 0100000.
  - 011 (SLTU) and any other funct7 → illegal.
- I-ALU (0010011), SrcA=rs1, SrcB=imm:
  - 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND.
  - Shifts 001/101: SrcB = zero-extended instr[24:20]. Funct7 rules match R-type.
  - 011 → illegal.
- Load (0000011) / Store (0100011) / JALR (1100111): ADD, rs1+imm.
- LUI (0110111): ADD, SrcA=0, SrcB=imm.
- Branch (1100011): SrcA=rs1, SrcB=rs2, is_branch=1.
  - BEQ 000: EQ, inv=0. BNE 001: EQ, inv=1.
  - BLT 100: SLT, inv=0. BGE 101: SLT, inv=1.
  - Other funct3 → illegal.
- Illegal or unlisted opcode: entry still issues, out_valid follows the handshake, illegal=1, Operation=0010, SrcA=SrcB=0, is_branch=0.
- Outputs are registered only; there is no combinational path from instr to Operation.

Test Plan:
- Reset: hold reset_n=0 two cycles with in_valid=1 → out_valid=0, Operation=0010, all data 0. Release → first accepted instr appears 1 cycle after load.
- ALU coverage: SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 → Operation=0110, SrcA=10, SrcB=3. SRAI x1,x1,4 (0x4040D093) → Operation=0111, SrcB=4 regardless of imm upper bits.
- Branches: BNE (funct3 001), rs1=5, rs2=5 → Operation=1000, is_branch=1, branch_inv=1. BGE → 1100, inv=1.
- Stall: load ADD, hold out_ready=0 for 3 cycles while in_valid=1 with a new instr → outputs unchanged, in_ready=0. out_ready=1 → new instr accepted and visible the next cycle; back-to-back throughput 1/cycle.
- Flush: out_valid=1 with flush=1, in_valid=1, out_ready=1 → next cycle out_valid=0 and the incoming instr never appears.
- Illegal: SLTU (funct3 011 R-type), then opcode 0x7F → illegal=1, Operation=0010, SrcA=SrcB=0. The following legal ADDI clears illegal.
